add_sub_stream: RTL and testbench
=================================

// Module: add_sub_stream
// PURPOSE
//  Streaming front-end for the n-bit unsigned add/subtract unit (add_sub_bit). Accepts packed stimulus
//  words (a, b, op) over valid/ready, buffers them in a small FIFO and drives add_sub_bit from the FIFO head.
//  It registers result/carry into a valid/ready output stage, tagged with a sequence index.
//  The golden-file checker consumes that output stream.
// PARAMETERS
//  DATA_WIDTH   4                  operand width N
//  GOLDEN_WIDTH DATA_WIDTH+1       result width
//  INPUT_WIDTH  2*DATA_WIDTH+2     packed input word width
//  DEPTH        4                  FIFO entries (power of 2, >=2)
//  IDX_WIDTH    9                  sequence tag width (512 vectors)
// PORTS
//  clk         in   1             rising-edge clock
//  rst_n       in   1             synchronous reset, active low
//  in_valid    in   1             input word valid
//  in_ready    out  1             FIFO can accept a word
//  in_data     in   INPUT_WIDTH   [IW-1 -: N]=a, [IW-N-1 -: N]=b, [1]=unused, [0]=op
//  out_valid   out  1             result register holds a result
//  out_ready   in   1             consumer accepts result
//  out_result  out  GOLDEN_WIDTH  result from add_sub_bit
//  out_carry   out  1             carry_out from add_sub_bit
//  out_op      out  1             op of this result
//  out_idx     out  IDX_WIDTH     sequence number of this result
// BEHAVIOUR
//  - Arithmetic: op=0 add: result = a+b (N+1 bits, no loss). op=1 sub: result = {a<b, (a-b) mod 2^N}.
//    carry_out = result[GOLDEN_WIDTH-1] in both cases. Bit 1 of in_data is ignored.
//  - Input accept: in_valid && in_ready at a rising edge. in_ready = (count != DEPTH).
//    It depends only on FIFO state, never on in_valid or out_ready.
//  - FIFO: no bypass. An accepted word is written at edge k and is visible at the head from cycle k+1.
//  - Output load: at an edge where FIFO is non-empty and (!out_valid || out_ready), pop the head.
//    Register add_sub_bit outputs, head op and the idx counter. Set out_valid=1, then idx <= idx+1.
//  - Output hold: while out_valid && !out_ready, all out_* are held stable.
//  - Latency: 2 edges from input accept to out_valid=1 with empty FIFO and no stall.
//    Throughput: 1 result per cycle.
//  - Simultaneous push+pop: allowed at any count; count unchanged. When full, in_ready=0,
//    so push is refused even if a pop occurs that cycle.
//  - Empty: no pop. If out_ready, out_valid drops to 0 at the next edge.
//  - Wrap: FIFO pointers wrap modulo DEPTH. idx wraps 2^IDX_WIDTH-1 -> 0.
//  - Reset (rst_n=0 at edge, any time incl. mid-stream): FIFO flushed, pointers/count=0, idx=0,
//    out_valid=0, out_result=0, out_carry=0, out_op=0, out_idx=0. in_ready=0 while rst_n=0
//    and 1 from the first edge after release. In-flight words are discarded.
// CONFIGURATION
//  ADD_SUB_STREAM_STATS_EN defined: extra outputs stat_ops[15:0] and stat_carry[15:0].
//    stat_ops counts output handshakes (out_valid && out_ready). stat_carry counts those with out_carry=1.
//    Both saturate at 16'hFFFF and reset to 0.
//  Not defined: ports and counters absent. All other behaviour is identical.
// STRUCTURE
//  - Shared package add_sub_pkg (include add_sub_pkg.vh): OP_ADD=1'b0, OP_SUB=1'b1,
//    input field offsets A_MSB/B_MSB/OP_BIT as functions of DATA_WIDTH.
//  - Sub-module: stream_fifo (DEPTH x INPUT_WIDTH, count-based full/empty).
//  - Arithmetic: one instance of add_sub_bit #(DATA_WIDTH) on the FIFO head fields.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles -> all outputs 0, in_ready=0; first edge after release -> in_ready=1.
//  2 Single add: a=4'hF,b=4'h1,op=0, out_ready=1 -> 2 edges later out_valid=1, result=5'h10, carry=1, idx=0.
//  3 Sub borrow: a=4'h3,b=4'h5,op=1 -> result=5'h1E, carry=1. Then a=5,b=3,op=1 -> result=5'h02, carry=0.
//  4 Backpressure: out_ready=0, push 5 words -> 1 in out reg + 4 in FIFO, in_ready=0.
//    Outputs stable; release out_ready -> 5 results in order, idx 0..4.
//  5 Full-rate streaming: all 512 packed vectors with in_valid=out_ready=1 -> 1 result/cycle,
//    every result matches the golden file, idx wraps 511->0 on the next vector.
//  6 Reset mid-stream: 3 words queued, rst_n=0 one cycle -> out_valid=0, FIFO empty,
//    next accepted word emerges with idx=0.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared constants for the add/sub stream: opcode encodings and packed input field offsets.
// Latency: none (package only).
// Backpressure: none (package only).
package add_sub_pkg;

  // Opcode encodings carried in the low bit of the packed input word
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Fixed low-order bit positions of the packed word: [1] is a spare, [0] is op
  localparam int OP_BIT     = 0;
  localparam int UNUSED_BIT = 1;

  // MSB of operand a in a packed word {a, b, spare, op}
  function automatic int A_MSB(input int data_width);
    return 2 * data_width + 1;
  endfunction

  // MSB of operand b in a packed word {a, b, spare, op}
  function automatic int B_MSB(input int data_width);
    return data_width + 1;
  endfunction

  // Total packed input word width for a given operand width
  function automatic int IN_WIDTH(input int data_width);
    return 2 * data_width + 2;
  endfunction

endpackage

// File: rtl/add_sub_bit.sv
// N-bit unsigned add/subtract, ripple-carry; subtract is a + ~b + 1 and reports borrow in the top bit.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module add_sub_bit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         op,
  output logic [N:0]   result,
  output logic         carry_out
);

  import add_sub_pkg::*;

  // Ripple chain: op seeds the carry-in and inverts b, so one adder serves both ops.
  // For subtract the chain carry is "no borrow", so the top bit is its complement.
  always_comb begin : ripple
    logic c;
    logic bi;
    logic [N-1:0] sum;
    c   = (op == OP_SUB);
    bi  = 1'b0;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      bi     = b[i] ^ (op == OP_SUB);
      sum[i] = a[i] ^ bi ^ c;
      c      = (a[i] & bi) | (a[i] & c) | (bi & c);
    end
    result = {((op == OP_SUB) ? ~c : c), sum};
  end

  assign carry_out = result[N];

endmodule

// File: rtl/stream_fifo.sv
// Count-based synchronous FIFO, no bypass: a word written at edge k is at the head from cycle k+1.
// Latency: 1 edge write-to-head.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
module stream_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage needs no reset: reset clears the pointers, which makes every entry invisible.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/add_sub_stream.sv
// Streaming front-end: buffers packed {a,b,spare,op} words, computes a+b / a-b on the head, tags with idx.
// Latency: 2 edges from input accept to out_valid with an empty FIFO; 1 result per cycle sustained.
// Backpressure: in_ready reflects FIFO space only; out_* held while out_valid && !out_ready.
// Optional ADD_SUB_STREAM_STATS_EN adds saturating handshake/carry counters stat_ops and stat_carry.
module add_sub_stream #(
  parameter int DATA_WIDTH   = 4,
  parameter int GOLDEN_WIDTH = DATA_WIDTH + 1,
  parameter int INPUT_WIDTH  = 2 * DATA_WIDTH + 2,
  parameter int DEPTH        = 4,
  parameter int IDX_WIDTH    = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUT_WIDTH-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [GOLDEN_WIDTH-1:0] out_result,
  output logic                    out_carry,
  output logic                    out_op,
  output logic [IDX_WIDTH-1:0]    out_idx
`ifdef ADD_SUB_STREAM_STATS_EN
  ,
  output logic [15:0]             stat_ops,
  output logic [15:0]             stat_carry
`endif
);

  import add_sub_pkg::*;

  localparam int A_HI = A_MSB(DATA_WIDTH);
  localparam int B_HI = B_MSB(DATA_WIDTH);

  logic [INPUT_WIDTH-1:0]  fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    load;
  logic                    out_ready_q;
  logic [DATA_WIDTH-1:0]   head_a;
  logic [DATA_WIDTH-1:0]   head_b;
  logic                    head_op;
  logic [GOLDEN_WIDTH-1:0] alu_result;
  logic                    alu_carry;
  logic [IDX_WIDTH-1:0]    idx_cnt;
  logic                    unused_spare;

  // Becomes 1 at the first edge with rst_n high, so in_ready stays low through reset and
  // rises one edge after release.
  always_ff @(posedge clk) begin
    if (!rst_n) out_ready_q <= 1'b0;
    else        out_ready_q <= 1'b1;
  end

  assign in_ready = rst_n && out_ready_q && !fifo_full;
  assign push     = in_valid && in_ready;
  assign load     = !fifo_empty && (!out_valid || out_ready);

  stream_fifo #(
    .WIDTH (INPUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_data),
    .pop       (load),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_a       = fifo_head[A_HI -: DATA_WIDTH];
  assign head_b       = fifo_head[B_HI -: DATA_WIDTH];
  assign head_op      = fifo_head[OP_BIT];
  assign unused_spare = fifo_head[UNUSED_BIT];

  add_sub_bit #(
    .N (DATA_WIDTH)
  ) u_alu (
    .a         (head_a),
    .b         (head_b),
    .op        (head_op),
    .result    (alu_result),
    .carry_out (alu_carry)
  );

  // Output stage: load from the FIFO head when the register is free or being drained,
  // otherwise drop valid once the consumer takes the last result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_op     <= 1'b0;
      out_idx    <= '0;
      idx_cnt    <= '0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_carry  <= alu_carry;
      out_op     <= head_op;
      out_idx    <= idx_cnt;
      idx_cnt    <= idx_cnt + IDX_WIDTH'(1);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef ADD_SUB_STREAM_STATS_EN
  // Saturating counters of output handshakes and of those that carried/borrowed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops   <= '0;
      stat_carry <= '0;
    end else if (out_valid && out_ready) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (out_carry && (stat_carry != 16'hFFFF)) stat_carry <= stat_carry + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_add_sub_stream.sv
// Directed bench for add_sub_stream: reset, add/sub, backpressure, full-rate stream, mid-stream reset.
// Latency: inputs driven on negedge, outputs sampled on negedge.
// Backpressure: bench drives out_ready explicitly per scenario.
module tb_add_sub_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_result;
  logic       out_carry;
  logic       out_op;
  logic [8:0] out_idx;
`ifdef ADD_SUB_STREAM_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_carry;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_sub_stream dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_op     (out_op),
    .out_idx    (out_idx)
`ifdef ADD_SUB_STREAM_STATS_EN
    ,
    .stat_ops   (stat_ops),
    .stat_carry (stat_carry)
`endif
  );

  // Backpressure vectors and hand-computed results
  logic [3:0] bp_a   [5] = '{4'h1, 4'h9, 4'h7, 4'h0, 4'hF};
  logic [3:0] bp_b   [5] = '{4'h2, 4'h8, 4'h7, 4'h1, 4'hF};
  logic       bp_op  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [4:0] bp_res [5] = '{5'h03, 5'h11, 5'h00, 5'h1F, 5'h1E};

  function automatic logic [9:0] pack(input logic [3:0] a, input logic [3:0] b,
                                      input logic spare, input logic op);
    return {a, b, spare, op};
  endfunction

  // Reference arithmetic for the exhaustive stream
  function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b, input logic op);
    logic [4:0] r;
    if (op) r = {(a < b), 4'(a - b)};
    else    r = {1'b0, a} + {1'b0, b};
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offers one word and waits (bounded) for it to be accepted; returns at the negedge after accept.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic op);
    logic ok;
    ok       = 1'b0;
    in_data  = pack(a, b, 1'b0, op);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = in_ready;
      cycle();
    end
    in_valid = 1'b0;
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL send_accept: accepted=%0b required=1", ok);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_result !== 5'h00) begin errors++; $display("FAIL reset_out_result: got %h want 00", out_result); end
    checks++; if (out_carry !== 1'b0) begin errors++; $display("FAIL reset_out_carry: got %0b want 0", out_carry); end
    checks++; if (out_op !== 1'b0) begin errors++; $display("FAIL reset_out_op: got %0b want 0", out_op); end
    checks++; if (out_idx !== 9'd0) begin errors++; $display("FAIL reset_out_idx: got %0d want 0", out_idx); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    rst_n = 1'b1;
    cycle();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_single_add();
    out_ready = 1'b1;
    send(4'hF, 4'h1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_latency_early: out_valid=%0b want 0", out_valid); end
    cycle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %0b want 1", out_valid); end
    checks++; if (out_result !== 5'h10) begin errors++; $display("FAIL add_result: got %h want 10", out_result); end
    checks++; if (out_carry !== 1'b1) begin errors++; $display("FAIL add_carry: got %0b want 1", out_carry); end
    checks++; if (out_op !== 1'b0) begin errors++; $display("FAIL add_op: got %0b want 0", out_op); end
    checks++; if (out_idx !== 9'd0) begin errors++; $display("FAIL add_idx: got %0d want 0", out_idx); end
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_drop_valid: got %0b want 0", out_valid); end
  endtask

  task automatic test_sub_borrow();
    out_ready = 1'b1;
    send(4'h3, 4'h5, 1'b1);
    cycle();
    checks++; if (out_result !== 5'h1E) begin errors++; $display("FAIL sub_borrow_result: got %h want 1e", out_result); end
    checks++; if (out_carry !== 1'b1) begin errors++; $display("FAIL sub_borrow_carry: got %0b want 1", out_carry); end
    checks++; if (out_op !== 1'b1) begin errors++; $display("FAIL sub_borrow_op: got %0b want 1", out_op); end
    checks++; if (out_idx !== 9'd1) begin errors++; $display("FAIL sub_borrow_idx: got %0d want 1", out_idx); end
    send(4'h5, 4'h3, 1'b1);
    cycle();
    checks++; if (out_result !== 5'h02) begin errors++; $display("FAIL sub_result: got %h want 02", out_result); end
    checks++; if (out_carry !== 1'b0) begin errors++; $display("FAIL sub_carry: got %0b want 0", out_carry); end
    checks++; if (out_idx !== 9'd2) begin errors++; $display("FAIL sub_idx: got %0d want 2", out_idx); end
    cycle();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data  = pack(bp_a[i], bp_b[i], 1'b0, bp_op[i]);
      in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_fill_ready[%0d]: got %0b want 1", i, in_ready); end
      cycle();
    end
    // Sixth word offered while full must be refused
    in_data = pack(4'h2, 4'h2, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %0b want 0", in_ready); end
    repeat (3) cycle();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready: got %0b want 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %0b want 1", out_valid); end
    checks++; if (out_result !== 5'h03) begin errors++; $display("FAIL bp_hold_result: got %h want 03", out_result); end
    checks++; if (out_idx !== 9'd0) begin errors++; $display("FAIL bp_hold_idx: got %0d want 0", out_idx); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== bp_res[i] || out_carry !== bp_res[i][4] ||
          out_op !== bp_op[i] || out_idx !== 9'(i)) begin
        errors++;
        $display("FAIL bp_drain[%0d]: got v=%0b r=%h c=%0b op=%0b idx=%0d want v=1 r=%h c=%0b op=%0b idx=%0d",
                 i, out_valid, out_result, out_carry, out_op, out_idx,
                 bp_res[i], bp_res[i][4], bp_op[i], i);
      end
      cycle();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_done: out_valid=%0b want 0", out_valid); end
  endtask

  task automatic test_streaming();
    int         sent;
    int         got;
    int         first_cyc;
    int         last_cyc;
    logic       acc;
    logic [8:0] v;
    logic [8:0] ev;
    logic [4:0] er;
    do_reset();
    out_ready = 1'b1;
    sent      = 0;
    got       = 0;
    first_cyc = -1;
    last_cyc  = -1;
    for (int cyc = 0; cyc < 1200 && got < 513; cyc++) begin
      if (sent < 513) begin
        v        = 9'(sent);
        in_data  = pack(v[8:5], v[4:1], v[3], v[0]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid === 1'b1) begin
        ev = 9'(got);
        er = model(ev[8:5], ev[4:1], ev[0]);
        checks++;
        if (out_result !== er || out_carry !== er[4] || out_op !== ev[0] || out_idx !== ev) begin
          errors++;
          $display("FAIL stream[%0d]: got r=%h c=%0b op=%0b idx=%0d want r=%h c=%0b op=%0b idx=%0d",
                   got, out_result, out_carry, out_op, out_idx, er, er[4], ev[0], ev);
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      acc = in_valid && in_ready;
      cycle();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    checks++; if (got != 513) begin errors++; $display("FAIL stream_count: got %0d results want 513", got); end
    checks++;
    if (last_cyc - first_cyc != 512) begin
      errors++;
      $display("FAIL stream_rate: %0d cycles for 513 results want 512", last_cyc - first_cyc);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_data  = pack(4'(i), 4'(i), 1'b0, 1'b0);
      in_valid = 1'b1;
      cycle();
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %0b want 1", out_valid); end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_idx !== 9'd0) begin errors++; $display("FAIL mid_out_idx: got %0d want 0", out_idx); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready: got %0b want 0", in_ready); end
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_fifo_empty: out_valid=%0b want 0", out_valid); end
    send(4'h6, 4'h2, 1'b1);
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 5'h04 || out_carry !== 1'b0 || out_idx !== 9'd0) begin
      errors++;
      $display("FAIL mid_first_word: got v=%0b r=%h c=%0b idx=%0d want v=1 r=04 c=0 idx=0",
               out_valid, out_result, out_carry, out_idx);
    end
    cycle();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_sub_borrow();
    test_backpressure();
    test_streaming();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

endmodule
